// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// Holds the FSM state type, the slice width and named function selects.
package alu_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // S codes; ADD and SUB run with M=0, XOR runs with M=1
   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;
   localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result bundle for the nibble sequencer.
// master: start, a, b, s, m, c_in -> ; <- busy, done, f, c_out, equal
interface alu_nibble_sequencer_if #(
   parameter int NIBBLES = 2
);
   import alu_seq_pkg::*;

   localparam int W = NIBBLE_W * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   s;
   logic         m;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] f;
   logic         c_out;
   logic         equal;

   modport master (
      output start, a, b, s, m, c_in,
      input  busy, done, f, c_out, equal
   );

   modport slave (
      input  start, a, b, s, m, c_in,
      output busy, done, f, c_out, equal
   );

endinterface

// File: rtl/alu_74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data.
// Ports: a, b, s, m, cn (1 = no carry) -> f, cn4 (0 = carry), aeqb.
module alu_74181 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cn,
   output logic [3:0] f,
   output logic       cn4,
   output logic       aeqb
);

   logic [3:0] t1;
   logic [3:0] t2;
   logic [4:0] sum;

   // The two per-bit terms of the 74181: every arithmetic
   // function is t1 + t2 + carry, every logic function is
   // the carry-free sum bit inverted.
   assign t1 = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
   assign t2 = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

   assign sum  = {1'b0, t1} + {1'b0, t2} + {4'b0, ~cn};
   assign f    = m ? ~(t1 ^ t2) : sum[3:0];
   // Carry output is produced in either mode, as on the part
   assign cn4  = ~sum[4];
   assign aeqb = &f;

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs a W-bit 74181 operation one nibble per enabled clock.
// Ports: clk, rstb (async low), ena (clock enable), bus (slave).
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NIBBLES = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic ena,
   alu_nibble_sequencer_if.slave bus
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_t         state;
   logic [IW-1:0]  idx;
   logic           carry;
   logic           eq_acc;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [3:0]     op_s;
   logic           op_m;
   logic [W-1:0]   f_work;
   logic [W-1:0]   f_q;
   logic           c_out_q;
   logic           equal_q;
   logic           done_q;

   logic [3:0]     nib_a;
   logic [3:0]     nib_b;
   logic [3:0]     sl_f;
   logic           sl_co;
   logic           sl_eq;
   logic [W-1:0]   f_next;

   assign nib_a = op_a[NIBBLE_W*idx +: NIBBLE_W];
   assign nib_b = op_b[NIBBLE_W*idx +: NIBBLE_W];

   alu_74181 u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .s    (op_s),
      .m    (op_m),
      .cn   (carry),
      .f    (sl_f),
      .cn4  (sl_co),
      .aeqb (sl_eq)
   );

   // Working result with the current nibble merged in
   always_comb begin
      f_next = f_work;
      f_next[NIBBLE_W*idx +: NIBBLE_W] = sl_f;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state   <= IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         eq_acc  <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         op_s    <= '0;
         op_m    <= 1'b0;
         f_work  <= '0;
         f_q     <= '0;
         c_out_q <= 1'b0;
         equal_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a   <= bus.a;
                  op_b   <= bus.b;
                  op_s   <= bus.s;
                  op_m   <= bus.m;
                  carry  <= bus.c_in;
                  idx    <= '0;
                  eq_acc <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               f_work <= f_next;
               carry  <= sl_co;
               eq_acc <= eq_acc & sl_eq;
               if (idx == LAST) begin
                  f_q     <= f_next;
                  c_out_q <= sl_co;
                  equal_q <= eq_acc & sl_eq;
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.busy  = (state == RUN);
   assign bus.done  = done_q;
   assign bus.f     = f_q;
   assign bus.c_out = c_out_q;
   assign bus.equal = equal_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer with NIBBLES=2.
// Directed cases plus random ops against a word-level 74181 model.
module tb_alu_nibble_sequencer;
   import alu_seq_pkg::*;

   localparam int NIB = 2;
   localparam int W   = 4 * NIB;
   localparam logic [3:0] S_AND = 4'b1011;

   typedef struct {
      logic [W-1:0] f;
      logic         co;
      logic         eq;
   } exp_t;

   logic clk = 1'b0;
   logic rstb;
   logic ena;
   logic last_ena = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   alu_nibble_sequencer_if #(.NIBBLES(NIB)) bus ();

   alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clk  (clk),
      .rstb (rstb),
      .ena  (ena),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Word-level reference: the carry chain depends only on S,
   // the visible result on S and M.
   function automatic exp_t model(input logic [W-1:0] a, b,
                                  input logic [3:0] s,
                                  input logic m, cin);
      exp_t e;
      logic [W:0] full;
      logic [W-1:0] ones;
      logic [W:0] ci;
      ones = '1;
      ci = (W+1)'(!cin);
      full = '0;
      e.f = '0;
      case (s)
         S_ADD: begin
            full = {1'b0, a} + {1'b0, b} + ci;
            e.f = m ? ~(a ^ b) : full[W-1:0];
         end
         S_SUB: begin
            full = {1'b0, a} + {1'b0, ~b} + ci;
            e.f = m ? (a ^ b) : full[W-1:0];
         end
         S_AND: begin
            full = {1'b0, a & b} + {1'b0, ones} + ci;
            e.f = m ? (a & b) : full[W-1:0];
         end
         default: ;
      endcase
      e.co = ~full[W];
      e.eq = (e.f == ones);
      return e;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   always @(posedge clk) last_ena = ena;

   // Monitor: a fresh done is one raised by an enabled edge
   always @(negedge clk) begin
      if (rstb && bus.done && last_ena) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done got=1 want=0 t=%0t",
                     $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result_f", 32'(bus.f), 32'(e.f));
            chk("result_c_out", 32'(bus.c_out), 32'(e.co));
            chk("result_equal", 32'(bus.equal), 32'(e.eq));
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, ib,
                        input logic [3:0] is,
                        input logic im, ic,
                        input bit push);
      bus.a = ia;
      bus.b = ib;
      bus.s = is;
      bus.m = im;
      bus.c_in = ic;
      bus.start = 1'b1;
      ena = 1'b1;
      if (push) q.push_back(model(ia, ib, is, im, ic));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         if (rnd) ena = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
         n++;
      end
      ena = 1'b1;
      chk("idle_wait", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int n;
      rstb = 1'b0;
      ena = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.s = '0;
      bus.m = 1'b0;
      bus.c_in = 1'b1;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_f", 32'(bus.f), 32'd0);
      chk("rst_c_out", 32'(bus.c_out), 32'd0);
      chk("rst_equal", 32'(bus.equal), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);
      #1;

      // Basic add with busy width and done alignment
      issue(8'h3C, 8'h5A, S_ADD, 1'b0, 1'b1, 1'b1);
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.busy && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("busy_len", 32'(n), 32'(NIB));
      chk("done_at_busy_fall", 32'(bus.done), 32'd1);
      @(posedge clk);
      #1;
      chk("done_pulse_clear", 32'(bus.done), 32'd0);

      // Carry out of top nibble, then carry between nibbles
      issue(8'hF0, 8'h20, S_ADD, 1'b0, 1'b1, 1'b1);
      wait_idle(1'b0);
      issue(8'h0F, 8'h01, S_ADD, 1'b0, 1'b1, 1'b1);
      wait_idle(1'b0);

      // Subtract: equality flag
      issue(8'h55, 8'h55, S_SUB, 1'b0, 1'b1, 1'b1);
      wait_idle(1'b0);
      issue(8'h55, 8'h54, S_SUB, 1'b0, 1'b1, 1'b1);
      wait_idle(1'b0);

      // XOR with enable held low for three edges mid-run
      issue(8'hA5, 8'hFF, S_XOR, 1'b1, 1'b1, 1'b1);
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("frozen_busy", 32'(bus.busy), 32'd1);
      ena = 1'b1;
      n = 3;
      while (!bus.done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("freeze_latency", 32'(n), 32'(NIB + 3));
      ena = 1'b0;
      @(posedge clk);
      #1;
      chk("done_held", 32'(bus.done), 32'd1);
      chk("f_held", 32'(bus.f), 32'h5A);
      ena = 1'b1;
      @(posedge clk);
      #1;
      chk("done_cleared", 32'(bus.done), 32'd0);

      // Start while busy is ignored
      issue(8'h12, 8'h34, S_ADD, 1'b0, 1'b1, 1'b1);
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_idle(1'b0);
      @(posedge clk);
      #1;
      chk("no_extra_busy", 32'(bus.busy), 32'd0);

      // Start held through done: back-to-back acceptance
      issue(8'h21, 8'h43, S_ADD, 1'b0, 1'b0, 1'b1);
      bus.start = 1'b1;
      bus.a = 8'h77;
      bus.b = 8'h11;
      bus.s = S_SUB;
      bus.m = 1'b0;
      bus.c_in = 1'b1;
      q.push_back(model(8'h77, 8'h11, S_SUB, 1'b0, 1'b1));
      n = 0;
      while (!bus.done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      chk("b2b_accept", 32'(bus.busy), 32'd1);
      chk("b2b_period", 32'(n), 32'(NIB + 1));
      wait_idle(1'b0);

      // Reset mid-run aborts with no result
      issue(8'h99, 8'h66, S_ADD, 1'b0, 1'b1, 1'b0);
      rstb = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_f", 32'(bus.f), 32'd0);
      #2;
      rstb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 32'(bus.done), 32'd0);
      end
      issue(8'h81, 8'h7F, S_ADD, 1'b0, 1'b1, 1'b1);
      wait_idle(1'b0);

      // Random ops with random enable gaps
      for (int i = 0; i < 40; i++) begin
         logic [3:0] rs;
         case ($urandom_range(0, 2))
            0: rs = S_ADD;
            1: rs = S_SUB;
            default: rs = S_AND;
         endcase
         issue(W'($urandom), W'($urandom), rs,
               1'($urandom), 1'($urandom), 1'b1);
         wait_idle(1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Nibble-serial controller that runs a configurable-width operation through a single 4-bit `alu_74181` slice, one nibble per enabled clock. It ripples carry between cycles and assembles the full-width result. It sits between the SPI configuration registers (operands, S, M, Cn) and the status registers (F, carry, equality). It replaces a chain of cascaded slices with one shared slice.

## Interface
Parameters:
- `NIBBLES`, 2: number of 4-bit slices processed; data width W = 4*NIBBLES; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable; low freezes every register.
- `start`  in  1  request; sampled on enabled edges while idle.
- `a`  in  W  operand A, captured at start.
- `b`  in  W  operand B, captured at start.
- `s`  in  4  74181 function select, captured at start.
- `m`  in  1  mode (1 = logic, 0 = arithmetic), captured at start.
- `c_in`  in  1  carry into nibble 0, 74181 polarity (1 = no carry), captured at start.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when a result is written.
- `f`  out  W  result, held until the next completion.
- `c_out`  out  1  Cn+4 of the last nibble, 74181 polarity (0 = carry out).
- `equal`  out  1  AND of all nibble A=B outputs.

## Operation
- States: IDLE, RUN.
- IDLE with `start` and `ena` high:
  - capture a, b, s, m, c_in into operand registers;
  - idx ← 0; carry ← c_in; eq_acc ← 1; go to RUN.
- RUN drives the slice combinationally: nibble idx of captured A and B, captured s and m, `cn` = carry.
- Each enabled RUN edge:
  - f_work[idx] ← slice F;
  - carry ← slice Cn+4;
  - eq_acc ← eq_acc & slice A=B;
  - idx ← idx+1.
- On the enabled edge where idx = NIBBLES-1, from the final slice values:
  - `f` ← f_work with nibble idx replaced by slice F;
  - `c_out` ← slice Cn+4;
  - `equal` ← eq_acc & slice A=B;
  - `done` ← 1; go to IDLE.
- `done` clears on the next enabled edge.
- `busy` = (state == RUN).
- `start` while busy is ignored; there is no queueing.
- Input changes after capture have no effect on the running sequence.
- idx width is clog2(NIBBLES), minimum 1; idx never wraps past NIBBLES-1.
- Reset values: state IDLE, `busy` 0, `done` 0, `f` 0, `c_out` 0, `equal` 0, internal registers 0.

## Timing
- Capture edge e0; nibble k is processed on edge e(k+1).
- Result, `done` rise and `busy` fall all occur on edge eNIBBLES, so latency is NIBBLES enabled edges after capture.
- Back-to-back operation:
  - `start` high during the `done` cycle is accepted at the next enabled edge;
  - throughput is one operation per NIBBLES+1 edges.
- `ena` low on any edge: no state change, and `done` is held rather than cleared. Latency counts enabled edges only.
- `rstb` low mid-sequence aborts immediately to reset values. No `done` is produced, and the partial result is discarded.
- NIBBLES = 1: capture edge, then the result on the next enabled edge.

## Structure
- Package `alu_seq_pkg`:
  - state enum (IDLE, RUN);
  - `NIBBLE_W` = 4;
  - named S/M constants for the test plan: `S_ADD` = 4'b1001, `S_SUB` = 4'b0110 with M=0, `S_XOR` = 4'b0110 with M=1.
- Sub-module: one `alu_74181` instance. All sequencing logic is local to this block.

## Test plan
- NIBBLES=2, A=0x3C, B=0x5A, S=1001, M=0, c_in=1, start → `done` 2 edges later; F=0x96, c_out=1, busy high for exactly 2 cycles.
- A=0xF0, B=0x20, add → F=0x10, c_out=0 (carry rippled out of the top nibble). Then A=0x0F, B=0x01 → F=0x10, c_out=1 (inter-nibble carry).
- Subtract S=0110, M=0, c_in=1: A=B=0x55 → F=0xFF, equal=1. A=0x55, B=0x54 → F=0x00, equal=0.
- Logic XOR M=1, S=0110, A=0xA5, B=0xFF → F=0x5A. Hold `ena` low 3 cycles mid-RUN → `done` delayed by exactly 3 cycles, result unchanged.
- `start` pulsed while busy, with different operands → ignored, first result returned. `start` held through the `done` cycle → second operation begins immediately.
- Assert `rstb` low during RUN → busy=0, done=0, f=0 immediately. No `done` pulse after release; the next start works normally.
